feed_arb: RTL

FEED_ARB -- requirements
Module: feed_arb

---
 rtl/feed_arb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/feed_arb.sv
// feed_arb: two-port round-robin packet arbiter merging byte streams A and B
// onto one AXI-Stream output. Grants are held for a whole packet; a granted
// port that stalls mid-packet for LOCK_TIMEOUT cycles loses its grant.
// Optional per-port completed-packet counters: define FEED_ARB_STATS_EN.
module feed_arb #(
  parameter int CNT_W        = 32,
  parameter int LOCK_TIMEOUT = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s0_axis_tdata,
  input  logic             s0_axis_tvalid,
  input  logic             s0_axis_tlast,
  output logic             s0_axis_tready,
  input  logic [7:0]       s1_axis_tdata,
  input  logic             s1_axis_tvalid,
  input  logic             s1_axis_tlast,
  output logic             s1_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tid,
  input  logic             m_axis_tready,
  output logic             abort_pulse
`ifdef FEED_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
`endif
);

  // Counter only needs to reach LOCK_TIMEOUT-1; the timeout fires on the
  // stall cycle that would take it to LOCK_TIMEOUT.
  localparam int STALL_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST =
    STALL_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t             state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               abort_q, abort_d;

  logic grant0, grant1;
  logic cur_sel, cur_valid, cur_last;

  // Output mux; rst gates the grant so outputs are quiet while reset is held
  always_comb begin
    grant0         = (state_q == GRANT0) && !rst;
    grant1         = (state_q == GRANT1) && !rst;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tid     = 1'b0;
    s0_axis_tready = grant0 & m_axis_tready;
    s1_axis_tready = grant1 & m_axis_tready;
    if (grant0) begin
      m_axis_tvalid = s0_axis_tvalid;
      m_axis_tdata  = s0_axis_tdata;
      m_axis_tlast  = s0_axis_tlast;
    end else if (grant1) begin
      m_axis_tvalid = s1_axis_tvalid;
      m_axis_tdata  = s1_axis_tdata;
      m_axis_tlast  = s1_axis_tlast;
      m_axis_tid    = 1'b1;
    end
    abort_pulse = abort_q;
  end

  // Arbitration, packet-end detection and stall timeout
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    stall_d   = stall_q;
    abort_d   = 1'b0;
    cur_sel   = (state_q == GRANT1);
    cur_valid = cur_sel ? s1_axis_tvalid : s0_axis_tvalid;
    cur_last  = cur_sel ? s1_axis_tlast  : s0_axis_tlast;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (s0_axis_tvalid && s1_axis_tvalid)
          state_d = rr_last_q ? GRANT0 : GRANT1;
        else if (s0_axis_tvalid)
          state_d = GRANT0;
        else if (s1_axis_tvalid)
          state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (cur_valid && m_axis_tready) begin
          stall_d = '0;
          if (cur_last) begin
            state_d   = IDLE;
            rr_last_d = cur_sel;
          end
        end else if (!cur_valid && (LOCK_TIMEOUT != 0)) begin
          if (stall_q == STALL_LAST) begin
            state_d   = IDLE;
            rr_last_d = cur_sel;
            abort_d   = 1'b1;
            stall_d   = '0;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      stall_q   <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      stall_q   <= stall_d;
      abort_q   <= abort_d;
    end
  end

`ifdef FEED_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Count packets completed by an accepted tlast beat; aborts never get here
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (state_q == GRANT0 && s0_axis_tvalid && m_axis_tready && s0_axis_tlast)
      cnt0_d = cnt0_q + CNT_W'(1);
    if (state_q == GRANT1 && s1_axis_tvalid && m_axis_tready && s1_axis_tlast)
      cnt1_d = cnt1_q + CNT_W'(1);
  end

  // Packet counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`endif

endmodule
